axi4_lite_regfile_slave: RTL and testbench

//  Parametrised AXI4-Lite slave register file, successor to the fixed 4-register slave.

---
 rtl/axi4_lite_regfile_slave.sv | 195 +++++++++++++++++++
 tb/tb_axi4_lite_regfile_slave.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_regfile_slave.sv
// AXI4-Lite register file slave: parametrised width/depth, DECERR on bad addresses.
// Define AXIL_REGFILE_RO_EN to make RO_MASK registers answer writes with SLVERR.
module axi4_lite_regfile_slave #(
   parameter int                  C_S_AXI_DATA_WIDTH = 32,
   parameter int                  C_S_AXI_ADDR_WIDTH = 6,
   parameter int                  NUM_REGS           = 8,
   parameter logic [31:0]         DECERR_DATA        = 32'hDEADDEAD,
   parameter logic [NUM_REGS-1:0] RO_MASK            = '0
) (
   input  logic                              S_AXI_ACLK,
   input  logic                              S_AXI_ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
   input  logic [2:0]                        S_AXI_AWPROT,
   input  logic                              S_AXI_AWVALID,
   output logic                              S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
   input  logic                              S_AXI_WVALID,
   output logic                              S_AXI_WREADY,
   output logic [1:0]                        S_AXI_BRESP,
   output logic                              S_AXI_BVALID,
   input  logic                              S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
   input  logic [2:0]                        S_AXI_ARPROT,
   input  logic                              S_AXI_ARVALID,
   output logic                              S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
   output logic [1:0]                        S_AXI_RRESP,
   output logic                              S_AXI_RVALID,
   input  logic                              S_AXI_RREADY
);

   localparam int DW       = C_S_AXI_DATA_WIDTH;
   localparam int AW       = C_S_AXI_ADDR_WIDTH;
   localparam int SW       = DW / 8;
   localparam int ADDR_LSB = $clog2(SW);
   localparam int IW       = AW - ADDR_LSB;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   logic [DW-1:0]  r_regs [NUM_REGS];
   logic           r_rst_done;

   logic           r_aw_held;
   logic [AW-1:0]  r_aw_addr;
   logic           r_w_held;
   logic [DW-1:0]  r_w_data;
   logic [SW-1:0]  r_w_strb;
   logic           r_bvalid;
   logic [1:0]     r_bresp;

   logic           r_rvalid;
   logic [1:0]     r_rresp;
   logic [DW-1:0]  r_rdata;

   logic           w_aw_hs;
   logic           w_w_hs;
   logic           w_ar_hs;
   logic           w_commit;
   logic [IW-1:0]  w_wr_idx;
   logic [1:0]     w_wr_dec;
   logic           w_wr_ro;
   logic [1:0]     w_wr_resp;
   logic [IW-1:0]  w_rd_idx;
   logic [1:0]     w_rd_dec;
   logic [DW-1:0]  w_decerr_data;
   logic           w_unused;

   function automatic logic [1:0] f_decode(input logic [AW-1:0] a);
      logic [IW-1:0] idx;
      idx = a[AW-1:ADDR_LSB];
      if (a[ADDR_LSB-1:0] != '0)
         return RESP_DECERR;
      if (32'(idx) >= NUM_REGS)
         return RESP_DECERR;
      return RESP_OKAY;
   endfunction

   assign S_AXI_AWREADY = r_rst_done & ~r_aw_held & ~r_bvalid;
   assign S_AXI_WREADY  = r_rst_done & ~r_w_held & ~r_bvalid;
   assign S_AXI_ARREADY = r_rst_done & ~r_rvalid;
   assign S_AXI_BVALID  = r_bvalid;
   assign S_AXI_BRESP   = r_bresp;
   assign S_AXI_RVALID  = r_rvalid;
   assign S_AXI_RRESP   = r_rresp;
   assign S_AXI_RDATA   = r_rdata;

   assign w_aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
   assign w_w_hs   = S_AXI_WVALID & S_AXI_WREADY;
   assign w_ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;
   assign w_commit = r_aw_held & r_w_held;

   assign w_wr_idx = r_aw_addr[AW-1:ADDR_LSB];
   assign w_wr_dec = f_decode(r_aw_addr);
   assign w_rd_idx = S_AXI_ARADDR[AW-1:ADDR_LSB];
   assign w_rd_dec = f_decode(S_AXI_ARADDR);

`ifdef AXIL_REGFILE_RO_EN
   assign w_wr_ro  = (w_wr_dec == RESP_OKAY) & RO_MASK[w_wr_idx];
   assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT};
`else
   assign w_wr_ro  = 1'b0;
   assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, RO_MASK};
`endif

   always_comb begin
      w_wr_resp = w_wr_dec;
      if (w_wr_ro)
         w_wr_resp = RESP_SLVERR;
   end

   always_comb begin
      w_decerr_data        = '0;
      w_decerr_data[31:0]  = DECERR_DATA;
   end

   // Readies stay low for the first cycle after reset is released.
   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN)
         r_rst_done <= 1'b0;
      else
         r_rst_done <= 1'b1;
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         r_aw_held <= 1'b0;
         r_aw_addr <= '0;
      end else if (w_commit) begin
         r_aw_held <= 1'b0;
      end else if (w_aw_hs) begin
         r_aw_held <= 1'b1;
         r_aw_addr <= S_AXI_AWADDR;
      end
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         r_w_held <= 1'b0;
         r_w_data <= '0;
         r_w_strb <= '0;
      end else if (w_commit) begin
         r_w_held <= 1'b0;
      end else if (w_w_hs) begin
         r_w_held <= 1'b1;
         r_w_data <= S_AXI_WDATA;
         r_w_strb <= S_AXI_WSTRB;
      end
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         r_bvalid <= 1'b0;
         r_bresp  <= RESP_OKAY;
      end else if (w_commit) begin
         r_bvalid <= 1'b1;
         r_bresp  <= w_wr_resp;
      end else if (r_bvalid && S_AXI_BREADY) begin
         r_bvalid <= 1'b0;
      end
   end

   // Non-blocking update means a same-edge read sees the pre-write value.
   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         for (int i = 0; i < NUM_REGS; i++)
            r_regs[i] <= '0;
      end else if (w_commit && (w_wr_resp == RESP_OKAY)) begin
         for (int b = 0; b < SW; b++) begin
            if (r_w_strb[b])
               r_regs[w_wr_idx][8*b +: 8] <= r_w_data[8*b +: 8];
         end
      end
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         r_rvalid <= 1'b0;
         r_rresp  <= RESP_OKAY;
         r_rdata  <= '0;
      end else if (w_ar_hs) begin
         r_rvalid <= 1'b1;
         r_rresp  <= w_rd_dec;
         if (w_rd_dec == RESP_OKAY)
            r_rdata <= r_regs[w_rd_idx];
         else
            r_rdata <= w_decerr_data;
      end else if (r_rvalid && S_AXI_RREADY) begin
         r_rvalid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_axi4_lite_regfile_slave.sv
// Directed self-checking bench for axi4_lite_regfile_slave (32-bit, 8 regs).
// Covers reset, strobes, ordering, DECERR, backpressure and same-edge read/write.
module tb_axi4_lite_regfile_slave;

   logic        clk = 1'b0;
   logic        rstn;
   logic [5:0]  awaddr;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [5:0]  araddr;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;

   int checks = 0;
   int errors = 0;

`ifdef AXIL_REGFILE_RO_EN
   localparam logic [5:0] A_T = 6'h10;
`else
   localparam logic [5:0] A_T = 6'h04;
`endif

   axi4_lite_regfile_slave #(
      .C_S_AXI_DATA_WIDTH (32),
      .C_S_AXI_ADDR_WIDTH (6),
      .NUM_REGS           (8),
      .DECERR_DATA        (32'hDEADDEAD),
      .RO_MASK            (8'h02)
   ) dut (
      .S_AXI_ACLK    (clk),
      .S_AXI_ARESETN (rstn),
      .S_AXI_AWADDR  (awaddr),
      .S_AXI_AWPROT  (awprot),
      .S_AXI_AWVALID (awvalid),
      .S_AXI_AWREADY (awready),
      .S_AXI_WDATA   (wdata),
      .S_AXI_WSTRB   (wstrb),
      .S_AXI_WVALID  (wvalid),
      .S_AXI_WREADY  (wready),
      .S_AXI_BRESP   (bresp),
      .S_AXI_BVALID  (bvalid),
      .S_AXI_BREADY  (bready),
      .S_AXI_ARADDR  (araddr),
      .S_AXI_ARPROT  (arprot),
      .S_AXI_ARVALID (arvalid),
      .S_AXI_ARREADY (arready),
      .S_AXI_RDATA   (rdata),
      .S_AXI_RRESP   (rresp),
      .S_AXI_RVALID  (rvalid),
      .S_AXI_RREADY  (rready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_aw(input logic [5:0] a);
      int n = 0;
      awaddr  = a;
      awvalid = 1'b1;
      while (!awready && n < 20) begin tick(); n++; end
      chk("aw_timeout", 64'(n < 20), 64'd1);
      tick();
      awvalid = 1'b0;
   endtask

   task automatic send_w(input logic [31:0] d, input logic [3:0] s);
      int n = 0;
      wdata  = d;
      wstrb  = s;
      wvalid = 1'b1;
      while (!wready && n < 20) begin tick(); n++; end
      chk("w_timeout", 64'(n < 20), 64'd1);
      tick();
      wvalid = 1'b0;
   endtask

   task automatic wait_b(output logic [1:0] r);
      int n = 0;
      bready = 1'b1;
      while (!bvalid && n < 20) begin tick(); n++; end
      chk("b_timeout", 64'(n < 20), 64'd1);
      r = bresp;
      tick();
      bready = 1'b0;
   endtask

   task automatic wait_r(output logic [31:0] d, output logic [1:0] r);
      int n = 0;
      rready = 1'b1;
      while (!rvalid && n < 20) begin tick(); n++; end
      chk("r_timeout", 64'(n < 20), 64'd1);
      d = rdata;
      r = rresp;
      tick();
      rready = 1'b0;
   endtask

   task automatic wr(input logic [5:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [1:0] r);
      int  n = 0;
      logic aw_hs;
      logic w_hs;
      awaddr  = a;
      awvalid = 1'b1;
      wdata   = d;
      wstrb   = s;
      wvalid  = 1'b1;
      while ((awvalid || wvalid) && n < 20) begin
         aw_hs = awvalid & awready;
         w_hs  = wvalid & wready;
         tick();
         if (aw_hs) awvalid = 1'b0;
         if (w_hs)  wvalid  = 1'b0;
         n++;
      end
      chk("wr_timeout", 64'(n < 20), 64'd1);
      awvalid = 1'b0;
      wvalid  = 1'b0;
      wait_b(r);
   endtask

   task automatic rd(input logic [5:0] a, output logic [31:0] d,
                     output logic [1:0] r);
      int n = 0;
      araddr  = a;
      arvalid = 1'b1;
      while (!arready && n < 20) begin tick(); n++; end
      chk("ar_timeout", 64'(n < 20), 64'd1);
      tick();
      arvalid = 1'b0;
      wait_r(d, r);
   endtask

   initial begin
      logic [31:0] d;
      logic [1:0]  r;
      logic [31:0] exp;
      logic        ok;

      rstn = 1'b0;
      awaddr = '0; awprot = '0; awvalid = 1'b0;
      wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
      araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
      repeat (3) tick();

      chk("rst_awready", 64'(awready), 64'd0);
      chk("rst_wready", 64'(wready), 64'd0);
      chk("rst_arready", 64'(arready), 64'd0);
      chk("rst_bvalid", 64'(bvalid), 64'd0);
      chk("rst_rvalid", 64'(rvalid), 64'd0);
      chk("rst_rdata", 64'(rdata), 64'd0);
      chk("rst_bresp", 64'(bresp), 64'd0);
      rstn = 1'b1;
      chk("rel_arready_low", 64'(arready), 64'd0);
      tick();
      chk("rel_readies_up", 64'({awready, wready, arready}), 64'h7);

      // basic write / readback
      wr(6'h00, 32'h11223344, 4'hF, r);
      chk("t1_bresp", 64'(r), 64'd0);
      rd(6'h00, d, r);
      chk("t1_rdata", 64'(d), 64'h11223344);
      chk("t1_rresp", 64'(r), 64'd0);

      // W five cycles ahead of AW
      send_w(32'hA5A55A5A, 4'hF);
      repeat (4) tick();
      chk("t2_no_early_b", 64'(bvalid), 64'd0);
      chk("t2_wready_held", 64'({awready, wready}), 64'b10);
      send_aw(A_T);
      wait_b(r);
      chk("t2_bresp", 64'(r), 64'd0);
      chk("t2_single_b", 64'(bvalid), 64'd0);
      rd(A_T, d, r);
      chk("t2_rdata", 64'(d), 64'hA5A55A5A);

      // every strobe pattern
      for (int s = 0; s < 16; s++) begin
         wr(A_T, 32'h0, 4'hF, r);
         wr(A_T, 32'hFFFFFFFF, 4'(s), r);
         chk($sformatf("t3_bresp_s%0d", s), 64'(r), 64'd0);
         rd(A_T, d, r);
         exp = '0;
         for (int k = 0; k < 4; k++)
            if (s[k]) exp[8*k +: 8] = 8'hFF;
         chk($sformatf("t3_rdata_s%0d", s), 64'(d), 64'(exp));
      end
      wr(A_T, 32'h0, 4'hF, r);

      // decode errors
      wr(6'h05, 32'h12345678, 4'hF, r);
      chk("t4_wr_misal", 64'(r), 64'd3);
      rd(6'h06, d, r);
      chk("t4_rd_misal_resp", 64'(r), 64'd3);
      chk("t4_rd_misal_data", 64'(d), 64'hDEADDEAD);
      wr(6'h20, 32'h12345678, 4'hF, r);
      chk("t4_wr_oor", 64'(r), 64'd3);
      rd(6'h20, d, r);
      chk("t4_rd_oor_resp", 64'(r), 64'd3);
      chk("t4_rd_oor_data", 64'(d), 64'hDEADDEAD);
      rd(6'h04, d, r);
      chk("t4_reg1_same", 64'(d), 64'h0);
      rd(6'h00, d, r);
      chk("t4_reg0_same", 64'(d), 64'h11223344);

      // back-pressure on B and R
      awaddr = 6'h08; wdata = 32'h55AA55AA; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1;
      araddr = 6'h00; arvalid = 1'b1;
      chk("t5_readies", 64'({awready, wready, arready}), 64'h7);
      tick();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      tick();
      chk("t5_bvalid", 64'(bvalid), 64'd1);
      chk("t5_rvalid", 64'(rvalid), 64'd1);
      ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (!bvalid || bresp !== 2'b00 || !rvalid || rresp !== 2'b00 ||
             rdata !== 32'h11223344 || awready || wready || arready)
            ok = 1'b0;
      end
      chk("t5_stable", 64'(ok), 64'd1);
      wait_b(r);
      chk("t5_bresp", 64'(r), 64'd0);
      wait_r(d, r);
      chk("t5_rdata", 64'(d), 64'h11223344);
      chk("t5_drained", 64'({bvalid, rvalid}), 64'd0);
      rd(6'h08, d, r);
      chk("t5_reg2", 64'(d), 64'h55AA55AA);

      // commit and read on the same edge
      awaddr = 6'h0C; wdata = 32'hABCDEF01; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      araddr = 6'h0C; arvalid = 1'b1;
      chk("t6_arready", 64'(arready), 64'd1);
      tick();
      arvalid = 1'b0;
      chk("t6_both_valid", 64'({bvalid, rvalid}), 64'b11);
      wait_b(r);
      chk("t6_bresp", 64'(r), 64'd0);
      wait_r(d, r);
      chk("t6_old_data", 64'(d), 64'h0);
      rd(6'h0C, d, r);
      chk("t6_new_data", 64'(d), 64'hABCDEF01);

`ifdef AXIL_REGFILE_RO_EN
      wr(6'h04, 32'h12345678, 4'hF, r);
      chk("ro_bresp", 64'(r), 64'd2);
      rd(6'h04, d, r);
      chk("ro_unchanged", 64'(d), 64'h0);
      chk("ro_rresp", 64'(r), 64'd0);
`endif

      // reset drops a held W beat
      send_w(32'h99999999, 4'hF);
      rstn = 1'b0;
      repeat (2) tick();
      rstn = 1'b1;
      tick();
      send_aw(6'h00);
      repeat (4) tick();
      chk("rst_no_commit", 64'(bvalid), 64'd0);
      chk("rst_w_dropped", 64'(wready), 64'd1);
      send_w(32'h00000077, 4'hF);
      wait_b(r);
      chk("rst_bresp", 64'(r), 64'd0);
      rd(6'h00, d, r);
      chk("rst_reg0", 64'(d), 64'h77);
      rd(6'h08, d, r);
      chk("rst_reg2_clr", 64'(d), 64'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
